// File: rtl/addh_serial_inc_arb_if.sv
// Request/operand, half-adder and result signals of the shared serial incrementer.
// DEC exists only when ADDH_SEQ_DEC_EN is defined.
interface addh_serial_inc_arb_if #(
  parameter int N = 2,
  parameter int W = 8
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   REQ;
  logic [N*W-1:0] DIN;
  logic [N-1:0]   GNT;
  logic           HA_A;
  logic           HA_B;
  logic           HA_S;
  logic           HA_CO;
  logic [W-1:0]   DOUT;
  logic           OVF;
  logic           VLD;
  logic [IDW-1:0] ID;
  logic           RDY;
`ifdef ADDH_SEQ_DEC_EN
  logic [N-1:0]   DEC;
`endif

  modport slave (
    input  REQ, DIN, HA_S, HA_CO, RDY,
`ifdef ADDH_SEQ_DEC_EN
    input  DEC,
`endif
    output GNT, HA_A, HA_B, DOUT, OVF, VLD, ID
  );

  modport master (
    output REQ, DIN, HA_S, HA_CO, RDY,
`ifdef ADDH_SEQ_DEC_EN
    output DEC,
`endif
    input  GNT, HA_A, HA_B, DOUT, OVF, VLD, ID
  );
endinterface

// File: rtl/addh_serial_inc_arb.sv
// Round-robin bit-serial +1 (or -1 with ADDH_SEQ_DEC_EN) over one external half adder; GNT to VLD W+1 cycles.
// Result held on VLD until RDY; REQ ignored while busy, so requesters stall until GNT.
module addh_serial_inc_arb #(
  parameter int N = 2,
  parameter int W = 8
) (
  input  logic                 CLK,
  input  logic                 RN,
  addh_serial_inc_arb_if.slave bus
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;
  localparam int KW  = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   sr_q, sr_d;
  logic [W-1:0]   r_q, r_d;
  logic           c_q, c_d;
  logic [KW-1:0]  k_q, k_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic           dec_q, dec_d;
  logic [N-1:0]   gnt;
  logic           found;
  int             sel;
  int             idx;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= IDLE;
      sr_q    <= '0;
      r_q     <= '0;
      c_q     <= 1'b0;
      k_q     <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      r_q     <= r_d;
      c_q     <= c_d;
      k_q     <= k_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      dec_q   <= dec_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    r_d     = r_q;
    c_d     = c_q;
    k_d     = k_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    dec_d   = dec_q;
    gnt     = '0;
    found   = 1'b0;
    sel     = 0;
    idx     = 0;

    // First requester at or after the pointer, wrapping.
    for (int j = 0; j < N; j++) begin
      idx = int'(ptr_q) + j;
      if (idx >= N) idx = idx - N;
      for (int i = 0; i < N; i++) begin
        if (!found && (i == idx) && bus.REQ[i]) begin
          found = 1'b1;
          sel   = i;
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          for (int i = 0; i < N; i++) begin
            if (i == sel) begin
              gnt[i] = 1'b1;
              sr_d   = bus.DIN[i*W +: W];
`ifdef ADDH_SEQ_DEC_EN
              dec_d  = bus.DEC[i];
`endif
            end
          end
          r_d     = '0;
          c_d     = 1'b1;
          k_d     = '0;
          owner_d = IDW'(sel);
          state_d = RUN;
        end
      end
      RUN: begin
        // Decrement runs as ~(~x + 1): invert operand bits in and sum bits out.
        r_d = (r_q >> 1) | (W'(bus.HA_S ^ dec_q) << (W - 1));
        c_d = bus.HA_CO;
        sr_d = sr_q >> 1;
        k_d = k_q + 1'b1;
        if (k_q == KW'(W - 1)) state_d = DONE;
      end
      DONE: begin
        if (bus.RDY) begin
          ptr_d   = (owner_q == IDW'(N - 1)) ? '0 : owner_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // GNT is combinational from REQ, so it is forced low while reset is held.
  assign bus.GNT  = RN ? gnt : '0;
  assign bus.HA_A = (state_q == RUN) & (sr_q[0] ^ dec_q);
  assign bus.HA_B = (state_q == RUN) & c_q;
  assign bus.VLD  = (state_q == DONE);
  assign bus.DOUT = bus.VLD ? r_q : '0;
  assign bus.OVF  = bus.VLD & c_q;
  assign bus.ID   = bus.VLD ? owner_q : '0;
endmodule
